// File: rtl/usb_rx_pkg.sv
// Shared constants for the USB receive path: bit timing and bit-stuffing limits.
package usb_rx_pkg;

    // System clocks per USB bit period and the phase at which a bit is sampled.
    localparam int CLKS_PER_BIT  = 8;
    localparam int SAMPLE_POINT  = 3;

    // Consecutive ones after which the next bit on the wire is a stuffed 0.
    localparam int MAX_ONES      = 6;

    // Data bits per received byte.
    localparam int BITS_PER_BYTE = 8;

    // Width of the ones-run counter (0..MAX_ONES).
    localparam int ONES_W        = $clog2(MAX_ONES + 1);

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and programmable wrap value.
// Counts 0..rollover_val, then wraps back to 0; rollover_flag is high while
// the count sits at rollover_val so the caller can detect the wrapping step.
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_d, count_q;

    // Next count: clear wins over enable; enable wraps at rollover_val.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/rx_timer.sv
// USB RX bit timer: tracks the bit phase (resynchronised on every D+ edge),
// samples once per bit, removes stuffed zeros and flags stuffing errors, and
// marks byte boundaries after every 8 shifted data bits.
module rx_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = usb_rx_pkg::CLKS_PER_BIT,
    parameter int SAMPLE_POINT = usb_rx_pkg::SAMPLE_POINT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic rcving,
    input  logic d_edge,
    input  logic d_orig,
    output logic shift_enable,
    output logic byte_received,
    output logic stuff_err
);

    localparam int PH_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(BITS_PER_BYTE);

    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
    localparam logic [PH_W-1:0]   PH_SAMPLE = PH_W'(SAMPLE_POINT);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_BYTE - 1);
    localparam logic [ONES_W-1:0] ONES_MAX  = ONES_W'(MAX_ONES);

    logic [PH_W-1:0]   phase;
    logic              phase_wrap;
    logic              phase_clear;
    logic [BIT_W-1:0]  bit_cnt;
    logic              bit_last;
    logic              sample;
    logic              shift_c;
    logic              stuff_err_c;
    logic [ONES_W-1:0] ones_d, ones_q;
    logic              byte_pend_d, byte_pend_q;

    // An edge realigns the bit clock: phase 0 on the cycle after the edge.
    assign phase_clear = !rcving || d_edge;

    flex_counter #(.WIDTH(PH_W)) u_phase_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (phase_clear),
        .count_enable (rcving),
        .rollover_val (PH_LAST),
        .count_out    (phase),
        .rollover_flag(phase_wrap)
    );

    flex_counter #(.WIDTH(BIT_W)) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (!rcving),
        .count_enable (shift_c),
        .rollover_val (BIT_LAST),
        .count_out    (bit_cnt),
        .rollover_flag(bit_last)
    );

    // Sample point; a coincident edge means the phase is stale, so skip it.
    // n_rst gating keeps outputs low for the whole reset, even mid-bit.
    assign sample = n_rst && rcving && !d_edge && (phase == PH_SAMPLE);

    // Ones-run tracking and stuff-bit removal on each sample.
    always_comb begin
        ones_d      = ones_q;
        shift_c     = 1'b0;
        stuff_err_c = 1'b0;
        if (!rcving) begin
            ones_d = '0;
        end else if (sample) begin
            if (ones_q == ONES_MAX) begin
                // Stuffed bit: drop it, restart the run, flag if not a 0.
                ones_d      = '0;
                stuff_err_c = d_orig;
            end else begin
                shift_c = 1'b1;
                ones_d  = d_orig ? ones_q + 1'b1 : '0;
            end
        end
    end

    // Byte boundary is registered one cycle after the 8th shift.
    always_comb begin
        byte_pend_d = shift_c && bit_last;
    end

    // Ones-run and pending-byte registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones_q      <= '0;
            byte_pend_q <= 1'b0;
        end else begin
            ones_q      <= ones_d;
            byte_pend_q <= byte_pend_d;
        end
    end

    assign shift_enable  = shift_c;
    assign stuff_err     = stuff_err_c;
    // Dropping rcving also kills a byte boundary that is still in flight.
    assign byte_received = byte_pend_q && rcving && n_rst;

    // Only the wrap flag of the bit counter and the phase value are consumed.
    logic unused_ok;
    assign unused_ok = &{1'b0, phase_wrap, bit_cnt};

endmodule

// File: tb/tb_rx_timer.sv
// Scoreboard bench for rx_timer: directed scenarios push expected output
// events (kind, absolute cycle); a negedge monitor pops and compares them.
module tb_rx_timer;

    logic clk = 1'b0;
    logic n_rst, rcving, d_edge, d_orig;
    logic shift_enable, byte_received, stuff_err;

    rx_timer #(.CLKS_PER_BIT(8), .SAMPLE_POINT(3)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .rcving       (rcving),
        .d_edge       (d_edge),
        .d_orig       (d_orig),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .stuff_err    (stuff_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 shift_enable, 1 byte_received, 2 stuff_err
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  t0 = 0;
    int  checks = 0;
    int  errors = 0;
    int  zero_req = 0, zero_seen = 0;
    int  drain_req = 0, drain_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            0:       return "shift_enable";
            1:       return "byte_received";
            default: return "stuff_err";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int rel);
        ev_t e;
        e.kind = kind;
        e.cyc  = t0 + rel;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int k);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got %s at cycle %0d (rel %0d), required none", kname(k), cyc, cyc - t0);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got %s at cycle %0d (rel %0d), required %s at cycle %0d (rel %0d)",
                         kname(k), cyc, cyc - t0, kname(e.kind), e.cyc, e.cyc - t0);
            end
        end
    endtask

    // Monitor: all comparisons happen here, away from the active edge.
    always @(negedge clk) begin
        if (shift_enable)  check_ev(0);
        if (byte_received) check_ev(1);
        if (stuff_err)     check_ev(2);
        if (zero_req != zero_seen) begin
            zero_seen = zero_req;
            checks++;
            if (shift_enable || byte_received || stuff_err) begin
                errors++;
                $display("FAIL outputs_zero: got se=%0b br=%0b serr=%0b, required 0 0 0",
                         shift_enable, byte_received, stuff_err);
            end
        end
        if (drain_req != drain_seen) begin
            drain_seen = drain_req;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_events: %0d still pending, first %s at cycle %0d, required 0 pending",
                         exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
                exp_q.delete();
            end
        end
    end

    // Raise rcving just after an edge; that window is rel cycle 0.
    task automatic start_rx();
        @(posedge clk); #1;
        rcving = 1'b1;
        t0     = cyc;
    endtask

    // Drive n windows; d_orig follows bits[] indexed by bit period.
    task automatic run_bits(input int n, input logic [15:0] bits);
        for (int i = 0; i < n; i++) begin
            d_orig = bits[((cyc - t0) / 8) % 16];
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_edge();
        d_edge = 1'b1;
        run_bits(1, 16'h0000);
        d_edge = 1'b0;
    endtask

    // Drop rcving, idle, then confirm every expected event was seen.
    task automatic stop_rx();
        rcving = 1'b0;
        d_orig = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        drain_req++;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        n_rst = 1'b0; rcving = 1'b0; d_edge = 1'b0; d_orig = 1'b0;
        repeat (2) @(posedge clk);
        #1 zero_req++;                       // reset state
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        zero_req++;                          // idle after release

        // Plain byte, no edges: shifts at 3,11,..,59, byte at 60.
        start_rx();
        for (int i = 0; i < 8; i++) expect_ev(0, 3 + 8 * i);
        expect_ev(1, 60);
        run_bits(64, 16'h0000);
        stop_rx();

        // Resync at phase 6 (rel 6) -> shift at 10; edge at sample point (rel 18)
        // suppresses it -> next shift at 22.
        start_rx();
        expect_ev(0, 3); expect_ev(0, 10); expect_ev(0, 22);
        run_bits(6, 16'h0000);
        pulse_edge();
        run_bits(11, 16'h0000);
        pulse_edge();
        run_bits(6, 16'h0000);
        stop_rx();

        // Six ones then a stuffed 0: sample 6 dropped, byte at 68.
        start_rx();
        for (int i = 0; i < 6; i++) expect_ev(0, 3 + 8 * i);
        expect_ev(0, 59); expect_ev(0, 67); expect_ev(1, 68);
        run_bits(72, 16'h003F);
        stop_rx();

        // Seven ones: stuff_err at sample 6 (rel 51), no shift there.
        start_rx();
        for (int i = 0; i < 6; i++) expect_ev(0, 3 + 8 * i);
        expect_ev(2, 51);
        expect_ev(0, 59); expect_ev(0, 67); expect_ev(1, 68);
        run_bits(72, 16'h007F);
        stop_rx();

        // A 0 at sample 5 restarts the run: only sample 12 is stuffed.
        start_rx();
        for (int i = 0; i < 8; i++) expect_ev(0, 3 + 8 * i);
        expect_ev(1, 60);
        for (int i = 8; i < 12; i++) expect_ev(0, 3 + 8 * i);
        run_bits(100, 16'h0FDF);
        stop_rx();

        // Abort after 5 shifts, then a fresh byte needs 8 new shifts.
        start_rx();
        for (int i = 0; i < 5; i++) expect_ev(0, 3 + 8 * i);
        run_bits(37, 16'h0000);
        stop_rx();
        start_rx();
        for (int i = 0; i < 8; i++) expect_ev(0, 3 + 8 * i);
        expect_ev(1, 60);
        run_bits(64, 16'h0000);
        stop_rx();

        // rcving dropped in the byte_received cycle: pending pulse is killed.
        start_rx();
        for (int i = 0; i < 8; i++) expect_ev(0, 3 + 8 * i);
        run_bits(60, 16'h0000);
        stop_rx();

        // Reset at phase 3: outputs low at once; counting restarts from 0.
        start_rx();
        run_bits(3, 16'h0000);
        n_rst = 1'b0;
        zero_req++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_rst = 1'b1;
        t0 = cyc;
        expect_ev(0, 3); expect_ev(0, 11); expect_ev(0, 19);
        run_bits(20, 16'h0000);
        stop_rx();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
